mult_seq: RTL and testbench

- Parametrised sequential shift-add multiplier. It is the next generation of the team's 8-bit start/ready multiplier.
- Generalised to WIDTH-bit operands with a per-operation signed/unsigned mode.
- Adds an explicit done pulse, back-to-back operation and synchronous reset.
- Used as a low-area multiply engine wherever a fixed multi-cycle latency is acceptable.

---
 rtl/mult_pkg.sv | 19 +
 rtl/mult_seq_if.sv | 29 ++
 rtl/mult_negate.sv | 18 +
 rtl/mult_seq.sv | 140 ++++++++++++++
 tb/tb_mult_seq.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/mult_pkg.sv
// mult_pkg
// Shared types and helpers for the sequential shift-add multiplier.
//   mult_state_t : FSM state encoding (IDLE, LOAD, RUN, DONE)
//   cnt_width()  : width of the iteration counter for a given operand width
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } mult_state_t;

    // The counter only has to reach WIDTH-1, so $clog2(WIDTH) bits suffice.
    function automatic int cnt_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/mult_seq_if.sv
// mult_seq_if
// Request/result bundle of the sequential multiplier.
//   start, signed_mode, a, b : request side, driven by the master
//   ready, busy, done, m     : status and product, driven by the multiplier
// master = requester, slave = multiplier.
interface mult_seq_if #(
    parameter int WIDTH = 8
);

    logic                   start;
    logic                   signed_mode;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   ready;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     m;

    modport master (
        output start, signed_mode, a, b,
        input  ready, busy, done, m
    );

    modport slave (
        input  start, signed_mode, a, b,
        output ready, busy, done, m
    );

endinterface

// File: rtl/mult_negate.sv
// mult_negate
// Combinational conditional two's-complement negation.
//   din  : N-bit input value
//   neg  : 1 = output the two's complement of din, 0 = pass din through
//   dout : N-bit result
// The most negative value negates to itself, which read as unsigned is
// exactly its magnitude, so no extra bit is needed for |x|.
module mult_negate #(
    parameter int N = 8
) (
    input  logic [N-1:0] din,
    input  logic         neg,
    output logic [N-1:0] dout
);

    assign dout = neg ? (~din + 1'b1) : din;

endmodule

// File: rtl/mult_seq.sv
// mult_seq
// Sequential shift-add multiplier, WIDTH-bit operands, signed or unsigned per
// operation, fixed WIDTH+2 cycle latency from accepted start to done.
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : mult_seq_if slave modport
//         start/signed_mode/a/b sampled while ready=1
//         ready = IDLE or DONE, busy = LOAD or RUN
//         done  = one-cycle pulse, m valid from that cycle and held until
//                 the next done
module mult_seq
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    mult_seq_if.slave  bus
);

    localparam int CW = cnt_width(WIDTH);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_LOAD = LOAD;
    localparam logic [1:0] ST_RUN  = RUN;
    localparam logic [1:0] ST_DONE = DONE;

    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    logic [1:0]           state;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic                 sm_q;
    logic [WIDTH-1:0]     mcand;
    logic [WIDTH-1:0]     mplr;
    logic                 neg;
    logic [2*WIDTH:0]     acc;
    logic [2*WIDTH:0]     acc_sum;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   m_q;
    logic [2*WIDTH-1:0]   m_fix;
    logic                 done_q;
    logic [WIDTH-1:0]     a_abs;
    logic [WIDTH-1:0]     b_abs;
    logic                 accept;

    assign accept = bus.start & ((state == ST_IDLE) | (state == ST_DONE));

    // Operands are captured raw at acceptance; magnitudes are formed from the
    // captured copies so later changes on the bus cannot leak into LOAD.
    mult_negate #(.N(WIDTH)) u_abs_a (
        .din  (a_q),
        .neg  (sm_q & a_q[WIDTH-1]),
        .dout (a_abs)
    );

    mult_negate #(.N(WIDTH)) u_abs_b (
        .din  (b_q),
        .neg  (sm_q & b_q[WIDTH-1]),
        .dout (b_abs)
    );

    mult_negate #(.N(2*WIDTH)) u_sign_fix (
        .din  (acc[2*WIDTH-1:0]),
        .neg  (neg),
        .dout (m_fix)
    );

    // Conditional add of the multiplicand into the upper W+1 bits. The
    // accumulator stays below 2^(2W) after every shift, so the upper part
    // never overflows its W+1 bits.
    always_comb begin
        acc_sum = acc;
        if (mplr[0]) begin
            acc_sum[2*WIDTH:WIDTH] = acc[2*WIDTH:WIDTH] + {1'b0, mcand};
        end
    end

    // done and m are registered on the edge that leaves DONE, giving the
    // WIDTH+2 cycle latency; a start seen in DONE goes straight to LOAD.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            a_q    <= '0;
            b_q    <= '0;
            sm_q   <= 1'b0;
            mcand  <= '0;
            mplr   <= '0;
            neg    <= 1'b0;
            acc    <= '0;
            cnt    <= '0;
            m_q    <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                a_q  <= bus.a;
                b_q  <= bus.b;
                sm_q <= bus.signed_mode;
            end
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    mcand <= a_abs;
                    mplr  <= b_abs;
                    neg   <= sm_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                    acc   <= '0;
                    cnt   <= '0;
                    state <= ST_RUN;
                end
                ST_RUN: begin
                    acc  <= acc_sum >> 1;
                    mplr <= mplr >> 1;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    m_q    <= m_fix;
                    done_q <= 1'b1;
                    state  <= accept ? ST_LOAD : ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ready = (state == ST_IDLE) | (state == ST_DONE);
    assign bus.busy  = (state == ST_LOAD) | (state == ST_RUN);
    assign bus.done  = done_q;
    assign bus.m     = m_q;

endmodule

// File: tb/tb_mult_seq.sv
// tb_mult_seq
// Directed bench for mult_seq at WIDTH=8 with a 10 ns clock. Expected
// products are hand-computed constants, plus an integer reference product
// for the corner-value sweep.
module tb_mult_seq;

    localparam int W = 8;

    logic clk;
    logic rst;

    mult_seq_if #(.WIDTH(W)) bus ();

    mult_seq #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          acceptCyc = 0;
    logic        doneAtAccept;
    logic [15:0] mAtAccept;

    // Free-running clock and edge counter used for latency measurement.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Hard stop in case the stimulus ever wedges.
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Waits (bounded) for ready at a falling edge, presents a request for one
    // rising edge, records the accept cycle and what done/m showed right
    // after that edge, then drops start on the next falling edge.
    task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv, input logic sm);
        int n;
        n = 0;
        while (bus.ready !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (bus.ready !== 1'b1) begin
            checkOutput("ready_timeout", 32'(bus.ready), 32'd1);
        end
        bus.start       = 1'b1;
        bus.a           = av;
        bus.b           = bv;
        bus.signed_mode = sm;
        @(posedge clk);
        #1;
        acceptCyc    = cyc;
        doneAtAccept = bus.done;
        mAtAccept    = bus.m;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic waitDone(output logic [15:0] mv, output int lat);
        bit found;
        found = 0;
        mv    = '0;
        lat   = -1;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                found = 1;
                mv    = bus.m;
                lat   = cyc - acceptCyc;
            end
        end
        if (!found) begin
            checkOutput("done_timeout", 32'd0, 32'd1);
        end
    endtask

    task automatic countDones(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) n++;
        end
    endtask

    function automatic logic [15:0] refProduct(input logic [7:0] av, input logic [7:0] bv,
                                               input logic sm);
        int p;
        if (sm) p = int'($signed(av)) * int'($signed(bv));
        else    p = int'(av) * int'(bv);
        return p[15:0];
    endfunction

    task automatic runOne(input string tag, input logic [7:0] av, input logic [7:0] bv,
                          input logic sm, input logic [15:0] expM);
        logic [15:0] mv;
        int          lat;
        applyStimulus(av, bv, sm);
        waitDone(mv, lat);
        checkOutput({tag, "_m"}, 32'(mv), 32'(expM));
        checkOutput({tag, "_lat"}, lat, 32'd10);
    endtask

    logic [7:0] corners [9] = '{8'h00, 8'h01, 8'h02, 8'h7F, 8'h80, 8'h81, 8'hFE, 8'hFF, 8'h55};

    initial begin
        logic [15:0] mv;
        logic [15:0] prevExp;
        int          lat;
        int          n;
        int          prevCyc;
        bit          first;

        bus.start       = 1'b0;
        bus.a           = '0;
        bus.b           = '0;
        bus.signed_mode = 1'b0;
        rst             = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state
        checkOutput("rst_ready", 32'(bus.ready), 32'd1);
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_done", 32'(bus.done), 32'd0);
        checkOutput("rst_m", 32'(bus.m), 32'd0);

        // Unsigned boundary, with done width and ready after completion
        runOne("ff_ff_u", 8'hFF, 8'hFF, 1'b0, 16'hFE01);
        checkOutput("ff_ff_u_ready", 32'(bus.ready), 32'd1);
        @(negedge clk);
        checkOutput("done_one_cycle", 32'(bus.done), 32'd0);
        checkOutput("m_held", 32'(bus.m), 32'hFE01);
        runOne("zero_u", 8'h00, 8'hAB, 1'b0, 16'h0000);

        // Signed corners and mode difference
        runOne("80_80_s", 8'h80, 8'h80, 1'b1, 16'h4000);
        runOne("ff_05_s", 8'hFF, 8'h05, 1'b1, 16'hFFFB);
        runOne("7f_80_s", 8'h7F, 8'h80, 1'b1, 16'hC080);
        runOne("ff_02_u", 8'hFF, 8'h02, 1'b0, 16'h01FE);
        runOne("ff_02_s", 8'hFF, 8'h02, 1'b1, 16'hFFFE);

        // start during RUN is ignored: 0x12*0x34 = 936 = 0x03A8
        applyStimulus(8'h12, 8'h34, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("ign_busy", 32'(bus.busy), 32'd1);
        bus.start       = 1'b1;
        bus.a           = 8'h55;
        bus.b           = 8'h55;
        bus.signed_mode = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        waitDone(mv, lat);
        checkOutput("ign_m", 32'(mv), 32'h03A8);
        checkOutput("ign_lat", lat, 32'd10);
        countDones(14, n);
        checkOutput("ign_no_extra_done", n, 32'd0);

        // Back-to-back: start in DONE of 5*6, then 3*4
        applyStimulus(8'h05, 8'h06, 1'b0);
        prevCyc = acceptCyc;
        applyStimulus(8'h03, 8'h04, 1'b0);
        checkOutput("b2b_spacing", acceptCyc - prevCyc, 32'd10);
        checkOutput("b2b_first_done", 32'(doneAtAccept), 32'd1);
        checkOutput("b2b_first_m", 32'(mAtAccept), 32'h001E);
        waitDone(mv, lat);
        checkOutput("b2b_second_m", 32'(mv), 32'h000C);
        checkOutput("b2b_second_lat", lat, 32'd10);

        // Reset during the 4th RUN cycle aborts the operation
        applyStimulus(8'h11, 8'h22, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_ready", 32'(bus.ready), 32'd1);
        checkOutput("abort_busy", 32'(bus.busy), 32'd0);
        checkOutput("abort_m", 32'(bus.m), 32'd0);
        checkOutput("abort_done", 32'(bus.done), 32'd0);
        countDones(14, n);
        checkOutput("abort_no_done", n, 32'd0);
        runOne("after_abort", 8'h06, 8'h07, 1'b0, 16'h002A);

        // rst and start in the same cycle: reset wins
        @(negedge clk);
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.a     = 8'h09;
        bus.b     = 8'h09;
        @(negedge clk);
        rst       = 1'b0;
        bus.start = 1'b0;
        checkOutput("rst_start_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        checkOutput("rst_start_busy_later", 32'(bus.busy), 32'd0);

        // Corner-value sweep, both modes, back-to-back starts
        first   = 1;
        prevExp = '0;
        prevCyc = 0;
        for (int sm = 0; sm < 2; sm++) begin
            for (int i = 0; i < 9; i++) begin
                for (int j = 0; j < 9; j++) begin
                    applyStimulus(corners[i], corners[j], sm[0]);
                    if (!first) begin
                        checkOutput("sweep_m", 32'(mAtAccept), 32'(prevExp));
                        checkOutput("sweep_done", 32'(doneAtAccept), 32'd1);
                        checkOutput("sweep_spacing", acceptCyc - prevCyc, 32'd10);
                    end
                    first   = 0;
                    prevExp = refProduct(corners[i], corners[j], sm[0]);
                    prevCyc = acceptCyc;
                end
            end
        end
        waitDone(mv, lat);
        checkOutput("sweep_last_m", 32'(mv), 32'(prevExp));
        checkOutput("sweep_last_lat", lat, 32'd10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
